mvb_tx_sequencer: RTL and testbench

Frame sequencer sitting directly upstream of the MVB `Encode` block. It holds a small host-loaded word buffer and streams one frame's worth of words into the encoder's write FIFO. It then drives `frame_length` / `S_frame` / `M_frame` and pulses `send_frame`, and waits for the encoder's `frame_over` before reporting completion. It replaces ad-hoc counter-driven stimulus with a deterministic, restartable handshake.

---
 rtl/mvb_pkg.sv | 22 ++
 rtl/mvb_tx_sequencer_if.sv | 21 ++
 rtl/mvb_word_buffer.sv | 22 ++
 rtl/mvb_tx_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_mvb_tx_sequencer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/mvb_pkg.sv
// Shared definitions for the MVB transmit sequencer: FSM encoding, buffer
// sizing and frame-type constants.
package mvb_pkg;

  localparam int MVB_WORDS_MAX    = 16;
  localparam int MVB_MASTER_WORDS = 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_GAP  = 3'd2,
    ST_SEND = 3'd3,
    ST_WAIT = 3'd4,
    ST_DONE = 3'd5
  } mvb_state_e;

  typedef enum logic {
    FRAME_SLAVE  = 1'b0,
    FRAME_MASTER = 1'b1
  } mvb_frame_e;

endpackage

// File: rtl/mvb_tx_sequencer_if.sv
// Sequencer-to-Encode link: FIFO write path, frame descriptor, send trigger
// and the encoder's end-of-frame indication.
interface mvb_tx_sequencer_if;
  logic        fifo_write_en;
  logic [15:0] fifo_data;
  logic [6:0]  frame_length;
  logic        S_frame;
  logic        M_frame;
  logic        send_frame;
  logic        frame_over;

  modport master (
    output fifo_write_en, fifo_data, frame_length, S_frame, M_frame, send_frame,
    input  frame_over
  );

  modport slave (
    input  fifo_write_en, fifo_data, frame_length, S_frame, M_frame, send_frame,
    output frame_over
  );
endinterface

// File: rtl/mvb_word_buffer.sv
// Host-loaded frame word store: one write port, one combinational read port.
// Contents are intentionally not reset.
module mvb_word_buffer #(
  parameter int WORDS_MAX = 16
) (
  input  logic        clk,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [3:0]  rd_addr,
  output logic [15:0] rd_data
);

  logic [15:0] mem_q [WORDS_MAX];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/mvb_tx_sequencer.sv
// Streams one buffered frame into the MVB encoder FIFO, triggers transmission
// and waits for frame_over. Optional WAIT watchdog: MVB_SEQ_TIMEOUT_EN.
//
// state | meaning
// IDLE  | accept host buffer writes and start
// LOAD  | push buffer words 0..N-1 into the encoder FIFO
// GAP   | idle spacing before the send trigger
// SEND  | send_frame asserted
// WAIT  | wait for frame_over rising edge (or watchdog)
// DONE  | issue done pulse, then back to IDLE
module mvb_tx_sequencer
  import mvb_pkg::*;
#(
  parameter int WORDS_MAX      = MVB_WORDS_MAX,
  parameter int GAP_CYCLES     = 4,
  parameter int SEND_PULSE     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      buf_wr_en,
  input  logic [3:0]                buf_wr_addr,
  input  logic [15:0]               buf_wr_data,
  input  logic                      start,
  input  logic                      cfg_master,
  input  logic [4:0]                cfg_words,
  mvb_tx_sequencer_if.master        tx,
  output logic                      busy,
  output logic                      done,
  output logic                      cfg_err,
  output logic                      timeout_err
);

  localparam int CNT_MAX = (GAP_CYCLES > SEND_PULSE) ? GAP_CYCLES : SEND_PULSE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  mvb_state_e       state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic [4:0]       n_q, n_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fo_q;
  logic             fifo_write_en_q, fifo_write_en_d;
  logic [15:0]      fifo_data_q, fifo_data_d;
  logic [6:0]       frame_length_q, frame_length_d;
  logic             s_frame_q, s_frame_d, m_frame_q, m_frame_d;
  logic             send_frame_q, send_frame_d;
  logic             busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;

  logic        idle_ok, wr_ok, fo_rise;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data, rd_word;
  logic [4:0]  n_start;

  // The done-pulse cycle is already IDLE but still reports busy, so it is
  // excluded from accepting host writes and starts.
  assign idle_ok = (state_q == ST_IDLE) && !busy_q;
  assign wr_ok   = buf_wr_en && idle_ok;
  assign fo_rise = tx.frame_over && !fo_q;
  assign rd_addr = (state_q == ST_IDLE) ? 4'd0 : idx_q[3:0];
  // Word 0 is fetched in the start cycle; forward a same-cycle host write.
  assign rd_word = (wr_ok && (buf_wr_addr == rd_addr)) ? buf_wr_data : rd_data;
  assign n_start = cfg_master ? 5'(MVB_MASTER_WORDS)
                 : ((cfg_words > 5'(WORDS_MAX)) ? 5'(WORDS_MAX) : cfg_words);

  mvb_word_buffer #(.WORDS_MAX(WORDS_MAX)) u_buf (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (buf_wr_addr),
    .wr_data (buf_wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

`ifdef MVB_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_err_q, timeout_err_d;
  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign timeout_err    = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    n_d             = n_q;
    cnt_d           = cnt_q;
    fifo_write_en_d = 1'b0;
    fifo_data_d     = '0;
    frame_length_d  = frame_length_q;
    s_frame_d       = s_frame_q;
    m_frame_d       = m_frame_q;
    send_frame_d    = 1'b0;
    done_d          = 1'b0;
    cfg_err_d       = 1'b0;
`ifdef MVB_SEQ_TIMEOUT_EN
    to_cnt_d        = to_cnt_q;
    timeout_err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start && idle_ok) begin
          if (!cfg_master && (cfg_words == 5'd0)) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d         = ST_LOAD;
            n_d             = n_start;
            idx_d           = 5'd1;
            fifo_write_en_d = 1'b1;
            fifo_data_d     = rd_word;
            frame_length_d  = {2'b00, n_start};
            s_frame_d       = !cfg_master;
            m_frame_d       = cfg_master;
          end
        end
      end
      ST_LOAD: begin
        if (idx_q < n_q) begin
          fifo_write_en_d = 1'b1;
          fifo_data_d     = rd_word;
          idx_d           = idx_q + 5'd1;
        end else begin
          state_d = ST_GAP;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d      = ST_SEND;
          send_frame_d = 1'b1;
          cnt_d        = CNT_W'(SEND_PULSE - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SEND: begin
        if (cnt_q == '0) begin
          state_d = ST_WAIT;
`ifdef MVB_SEQ_TIMEOUT_EN
          to_cnt_d = TO_W'(TIMEOUT_CYCLES - 1);
`endif
        end else begin
          send_frame_d = 1'b1;
          cnt_d        = cnt_q - 1'b1;
        end
      end
      ST_WAIT: begin
        if (fo_rise) begin
          state_d = ST_DONE;
`ifdef MVB_SEQ_TIMEOUT_EN
        end else if (to_cnt_q == '0) begin
          state_d       = ST_IDLE;
          timeout_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q - 1'b1;
`endif
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE) || (state_q == ST_DONE);
    if (!busy_d) begin
      frame_length_d = '0;
      s_frame_d      = 1'b0;
      m_frame_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      idx_q           <= '0;
      n_q             <= '0;
      cnt_q           <= '0;
      fo_q            <= 1'b0;
      fifo_write_en_q <= 1'b0;
      fifo_data_q     <= '0;
      frame_length_q  <= '0;
      s_frame_q       <= 1'b0;
      m_frame_q       <= 1'b0;
      send_frame_q    <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      cfg_err_q       <= 1'b0;
`ifdef MVB_SEQ_TIMEOUT_EN
      to_cnt_q        <= '0;
      timeout_err_q   <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      n_q             <= n_d;
      cnt_q           <= cnt_d;
      fo_q            <= tx.frame_over;
      fifo_write_en_q <= fifo_write_en_d;
      fifo_data_q     <= fifo_data_d;
      frame_length_q  <= frame_length_d;
      s_frame_q       <= s_frame_d;
      m_frame_q       <= m_frame_d;
      send_frame_q    <= send_frame_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      cfg_err_q       <= cfg_err_d;
`ifdef MVB_SEQ_TIMEOUT_EN
      to_cnt_q        <= to_cnt_d;
      timeout_err_q   <= timeout_err_d;
`endif
    end
  end

  assign tx.fifo_write_en = fifo_write_en_q;
  assign tx.fifo_data     = fifo_data_q;
  assign tx.frame_length  = frame_length_q;
  assign tx.S_frame       = s_frame_q;
  assign tx.M_frame       = m_frame_q;
  assign tx.send_frame    = send_frame_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign cfg_err          = cfg_err_q;

endmodule

// File: tb/tb_mvb_tx_sequencer.sv
// Randomized self-checking bench for mvb_tx_sequencer; expected outputs come
// from a per-frame timeline computed from N, GAP, SEND and the frame_over time.
module tb_mvb_tx_sequencer;

  localparam int G  = 4;
  localparam int SP = 2;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        buf_wr_en;
  logic [3:0]  buf_wr_addr;
  logic [15:0] buf_wr_data;
  logic        start;
  logic        cfg_master;
  logic [4:0]  cfg_words;
  logic        busy, done, cfg_err, timeout_err;

  mvb_tx_sequencer_if tx();

  mvb_tx_sequencer #(
    .WORDS_MAX      (16),
    .GAP_CYCLES     (G),
    .SEND_PULSE     (SP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .buf_wr_en   (buf_wr_en),
    .buf_wr_addr (buf_wr_addr),
    .buf_wr_data (buf_wr_data),
    .start       (start),
    .cfg_master  (cfg_master),
    .cfg_words   (cfg_words),
    .tx          (tx),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  logic [15:0] bufm [16];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] pack(input bit we, input logic [15:0] d, input int fl,
                                       input bit s, input bit m, input bit snd, input bit bsy,
                                       input bit dn, input bit ce, input bit tmo);
    return {1'b0, we, d, 7'(fl), s, m, snd, bsy, dn, ce, tmo};
  endfunction

  function automatic logic [31:0] obs();
    return {1'b0, tx.fifo_write_en, tx.fifo_data, tx.frame_length, tx.S_frame, tx.M_frame,
            tx.send_frame, busy, done, cfg_err, timeout_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [15:0] d);
    buf_wr_en = 1'b1; buf_wr_addr = a; buf_wr_data = d;
    tick();
    buf_wr_en = 1'b0;
    bufm[a] = d;
  endtask

  // Start is sampled at the edge closing cycle 0; outputs of cycle c are
  // sampled 1 time unit after the edge opening cycle c.
  task automatic run_frame(input bit master, input logic [4:0] words, input int r_off,
                           input bit noise, input bit same_wr, input logic [3:0] sw_addr,
                           input logic [15:0] sw_data, input string tag);
    int n, w, r, t_to, last, hold, endf, quiet;
    bit to_mode, stray, we;
    logic [15:0] ed [16];
    start = 1'b1; cfg_master = master; cfg_words = words;
    if (same_wr) begin
      buf_wr_en = 1'b1; buf_wr_addr = sw_addr; buf_wr_data = sw_data;
      bufm[sw_addr] = sw_data;
    end
    if (!master && words == 5'd0) begin
      tick();
      start = 1'b0; buf_wr_en = 1'b0;
      chk_val({tag, "/reject"}, obs(), pack(0, 16'h0, 0, 0, 0, 0, 0, 0, 1, 0));
      tick();
      chk_val({tag, "/reject_after"}, obs(), 32'h0);
      return;
    end
    n = master ? 1 : ((int'(words) > 16) ? 16 : int'(words));
    for (int k = 0; k < 16; k++) ed[k] = bufm[k];
    w = n + G + SP + 1;
    to_mode = 1'b0;
`ifdef MVB_SEQ_TIMEOUT_EN
    if (r_off >= TO) to_mode = 1'b1;
`endif
    r     = w + r_off;
    t_to  = w + TO;
    last  = to_mode ? t_to + 1 : r + 3;
    endf  = to_mode ? t_to - 1 : r + 2;
    quiet = to_mode ? t_to - 1 : r + 1;
    hold  = $urandom_range(1, 3);
    stray = noise && ($urandom_range(0, 1) == 1);
    tick();
    start = 1'b0; buf_wr_en = 1'b0;
    for (int c = 1; c <= last; c++) begin
      we = (c <= n);
      chk_val($sformatf("%s@c%0d", tag, c), obs(),
              pack(we, we ? ed[c-1] : 16'h0, (c <= endf) ? n : 0,
                   (c <= endf) && !master, (c <= endf) && master,
                   (c >= n + G + 1) && (c <= n + G + SP), c <= endf,
                   !to_mode && (c == r + 2), 0, to_mode && (c == t_to)));
      tx.frame_over = (!to_mode && c >= r && c < r + hold) || (stray && c == n + 1);
      if (noise && c <= quiet) begin
        start       = ($urandom_range(0, 3) == 0);
        cfg_master  = 1'($urandom_range(0, 1));
        cfg_words   = 5'($urandom_range(1, 20));
        buf_wr_en   = ($urandom_range(0, 1) == 1);
        buf_wr_addr = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(0, 15));
        buf_wr_data = 16'($urandom);
      end else begin
        start = 1'b0; buf_wr_en = 1'b0;
      end
      tick();
    end
    start = 1'b0; buf_wr_en = 1'b0; tx.frame_over = 1'b0;
  endtask

  initial begin
    rst = 1'b1; buf_wr_en = 1'b0; buf_wr_addr = '0; buf_wr_data = '0;
    start = 1'b0; cfg_master = 1'b0; cfg_words = '0; tx.frame_over = 1'b0;
    repeat (3) tick();
    chk_val("reset_held", obs(), 32'h0);
    rst = 1'b0;
    tick();
    chk_val("reset_release", obs(), 32'h0);

    for (int k = 0; k < 16; k++) host_write(4'(k), 16'($urandom));
    for (int k = 0; k < 4; k++) host_write(4'(k), 16'h7EC3 + 16'(k));

    run_frame(0, 5'd4, 1, 0, 0, 4'd0, 16'h0, "slave4");
    host_write(4'd0, 16'hA5A5);
    run_frame(1, 5'd7, 2, 0, 0, 4'd0, 16'h0, "master");
    run_frame(0, 5'd0, 1, 0, 0, 4'd0, 16'h0, "slave0");
    run_frame(0, 5'd20, 3, 0, 0, 4'd0, 16'h0, "slave20");
    run_frame(0, 5'd3, 2, 1, 0, 4'd0, 16'h0, "busy_writes");
    run_frame(0, 5'd4, 1, 0, 0, 4'd0, 16'h0, "old_buf0");
    run_frame(0, 5'd2, 1, 0, 1, 4'd0, 16'h1234, "same_cycle_wr");

    // Abort during LOAD: reset lands mid-cycle while word 2 is presented.
    start = 1'b1; cfg_master = 1'b0; cfg_words = 5'd6;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk_val("load_word2", obs(), pack(1, bufm[2], 6, 1, 0, 0, 1, 0, 0, 0));
    #2 rst = 1'b1;
    #1 chk_val("rst_async", obs(), 32'h0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_val($sformatf("rst_quiet%0d", c), obs(), 32'h0);
    end
    run_frame(0, 5'd5, 2, 0, 0, 4'd0, 16'h0, "after_rst");

    run_frame(0, 5'd3, TO + 16, 0, 0, 4'd0, 16'h0, "late_edge");

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 1) == 1)
        host_write(4'($urandom_range(0, 15)), 16'($urandom));
      run_frame(1'($urandom_range(0, 1)), 5'($urandom_range(0, 20)), $urandom_range(1, 10),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                16'($urandom), $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
